// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  localparam int unsigned DEFAULT_LEN = 32;
  localparam logic [DEFAULT_LEN-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam int unsigned BYTES_PER_WORD = DEFAULT_LEN / 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned len);
    return len / 8;
  endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Shifts received bytes in MSB-first and flags the byte that completes a word.
module prog_loader_byte_assembler
  import prog_loader_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_accept,
  input  logic [7:0]     i_byte,
  output logic [LEN-1:0] o_word,
  output logic           o_word_valid
);

  localparam int unsigned Bpw  = bytes_per_word(LEN);
  localparam int unsigned CntW = (Bpw > 1) ? $clog2(Bpw) : 1;

  // Only the low LEN-8 bits are kept; the top byte is always the oldest one shifted out.
  logic [LEN-9:0]  sr_q;
  logic [CntW-1:0] cnt_q;
  logic            last_byte;

  assign o_word       = {sr_q, i_byte};
  assign last_byte    = (cnt_q == CntW'(Bpw - 1));
  assign o_word_valid = i_accept && last_byte;

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (i_accept) begin
      sr_q  <= o_word[LEN-9:0];
      cnt_q <= last_byte ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a UART byte stream into program memory as words; holds the CPU while loading.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned     LEN               = DEFAULT_LEN,
  parameter int unsigned     RAM_DEPTH_PROGRAM = 2048,
  parameter int unsigned     ADDR_W            = 11,
  parameter logic [LEN-1:0]  HALT_WORD         = DEFAULT_HALT_WORD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN-1:0]    o_data,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_DEPTH_PROGRAM - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [LEN-1:0]      word_q;
  logic [ADDR_W:0]     count_q;
  logic                ovf_q;
  logic                start_ok;
  logic                accept;
  logic                is_halt;
  logic [LEN-1:0]      asm_word;
  logic                asm_word_valid;

  assign start_ok = i_start && (state_q == StIdle || state_q == StDone);
  assign is_halt  = (word_q == HALT_WORD);
  // A byte arriving during WRITE starts the next word unless loading is ending.
  assign accept   = i_rx_valid &&
                    (state_q == StRecv || (state_q == StWrite && state_d == StRecv));

  prog_loader_byte_assembler #(
    .LEN (LEN)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (start_ok),
    .i_accept     (accept),
    .i_byte       (i_rx_data),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (i_start) state_d = StRecv;
      StRecv:         if (asm_word_valid) state_d = StWrite;
      StWrite:        state_d = (is_halt || addr_q == LastAddr) ? StDone : StRecv;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    o_we   = (state_q == StWrite);
    o_busy = (state_q == StRecv) || (state_q == StWrite);
    o_done = (state_q == StDone);
  end

  // o_addr/o_data are separate registers so they only move when a write begins.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      addr_q     <= '0;
      out_addr_q <= '0;
      word_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
      if (state_q == StRecv && asm_word_valid) begin
        word_q     <= asm_word;
        out_addr_q <= addr_q;
      end
      if (state_q == StWrite) begin
        count_q <= count_q + 1'b1;
        if (!is_halt) begin
          if (addr_q == LastAddr) ovf_q  <= 1'b1;
          else                    addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign o_addr       = out_addr_q;
  assign o_data       = word_q;
  assign o_overflow   = ovf_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with a 4-word memory so overflow is reachable.
module tb_prog_loader;

  localparam int unsigned LEN    = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN-1:0]    data;
  } wr_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_start = 1'b0;
  logic [7:0]        i_rx_data = '0;
  logic              i_rx_valid = 1'b0;
  logic [ADDR_W-1:0] o_addr;
  logic [LEN-1:0]    o_data;
  logic              o_we;
  logic              o_busy;
  logic              o_done;
  logic              o_overflow;
  logic [ADDR_W:0]   o_word_count;

  int total = 0;
  int bad   = 0;
  wr_t exp_q[$];

  prog_loader #(
    .LEN               (LEN),
    .RAM_DEPTH_PROGRAM (DEPTH),
    .ADDR_W            (ADDR_W),
    .HALT_WORD         (32'hFFFF_FFFF)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_we         (o_we),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge i_clk) begin
    if (i_rst && o_we) begin
      wr_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", o_addr, o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_addr !== e.addr || o_data !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   o_addr, o_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  task automatic check_status(input string name, input logic busy, input logic done,
                              input logic ovf, input int cnt);
    check({name, "_busy"}, 32'(o_busy), 32'(busy));
    check({name, "_done"}, 32'(o_done), 32'(done));
    check({name, "_ovf"},  32'(o_overflow), 32'(ovf));
    check({name, "_cnt"},  32'(o_word_count), 32'(cnt));
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) tick();
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_we", 32'(o_we), 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 0);
    i_rst = 1'b1;
    tick();

    // Byte in IDLE is ignored; then normal load (byte after 0x05 lands in WRITE)
    send_byte(8'h99);
    check_status("idle", 1'b0, 1'b0, 1'b0, 0);
    pulse_start();
    expect_wr(0, 32'h2001_0005);
    expect_wr(1, 32'hFFFF_FFFF);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    drain("normal_drain");
    check_status("normal", 1'b0, 1'b1, 1'b0, 2);
    check("normal_hold_addr", 32'(o_addr), 32'd1);

    // Restart from DONE
    pulse_start();
    check_status("restart", 1'b1, 1'b0, 1'b0, 0);

    // Reset mid-word discards AA BB
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 0);
    check("midrst_data", o_data, 32'd0);
    pulse_start();
    expect_wr(0, 32'h0102_0304);
    expect_wr(1, 32'hFFFF_FFFF);
    send_word(32'h0102_0304);
    send_word(32'hFFFF_FFFF);
    drain("midrst_drain");
    check_status("midrst_end", 1'b0, 1'b1, 1'b0, 2);

    // Byte in WRITE cycle and i_start during RECV ignored
    pulse_start();
    expect_wr(0, 32'hA0A1_A2A3);
    expect_wr(1, 32'h1122_3344);
    expect_wr(2, 32'hFFFF_FFFF);
    send_byte(8'hA0);
    i_start = 1'b1;
    send_byte(8'hA1);
    i_start = 1'b0;
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_word(32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    drain("wrbyte_drain");
    check_status("wrbyte", 1'b0, 1'b1, 1'b0, 3);

    // Overflow: four writes fill memory, fifth word is dropped
    pulse_start();
    for (int i = 0; i < 4; i++) expect_wr(i, 32'(i + 1));
    for (int i = 0; i < 4; i++) send_word(32'(i + 1));
    send_word(32'h5566_7788);
    drain("ovf_drain");
    check_status("ovf", 1'b0, 1'b1, 1'b1, 4);
    check("ovf_hold_addr", 32'(o_addr), 32'd3);
    check("ovf_hold_data", o_data, 32'd4);

    // Restart clears the sticky flags
    pulse_start();
    check_status("ovf_restart", 1'b1, 1'b0, 1'b0, 0);
    expect_wr(0, 32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    drain("final_drain");
    check_status("final", 1'b0, 1'b1, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
